// File: rtl/kb_stopwatch_if.sv
// kb_stopwatch_if: keyboard FIFO read port between the make-code FIFO and the stopwatch.
//   fifo_empty : FIFO empty flag (FIFO -> consumer)
//   rd_data    : FIFO head {shift, scan[7:0]}, valid while fifo_empty=0
//   rd_fifo    : pop strobe, FIFO advances on the rising edge where it is 1 (consumer -> FIFO)
interface kb_stopwatch_if;
  logic       fifo_empty;
  logic [8:0] rd_data;
  logic       rd_fifo;
  modport master (output fifo_empty, rd_data, input rd_fifo);
  modport slave (input fifo_empty, rd_data, output rd_fifo);
endinterface

// File: rtl/kb_stopwatch.sv
// kb_stopwatch: pops keyboard scan codes, decodes G/P/C/U/D and runs an m:ss.d BCD stopwatch.
//   clk, rst_n : clock, asynchronous active-low reset
//   kb         : keyboard FIFO read port (slave side)
//   running    : stopwatch counting
//   up         : count direction, 1=up, 0=down
//   d0/s0/s1/m0: tenths, seconds units, seconds tens, minutes (BCD)
module kb_stopwatch #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  kb_stopwatch_if.slave kb,
  output logic       running,
  output logic       up,
  output logic [3:0] d0,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t          r_state;
  logic            r_rd;
  logic [8:0]      r_code;
  logic            r_run;
  logic            r_up;
  logic [15:0]     r_dig;
  logic [CW-1:0]   r_cnt;
  logic            w_exec, w_tick, w_zero, w_clr;
  logic            w_c0, w_c1, w_c2, w_b0, w_b1, w_b2;
  logic [15:0]     w_inc, w_dec;
  always_comb begin
    w_exec = r_state == EXEC;
    w_tick = r_run && r_cnt == CW'(TICK_DIV - 1);
    w_zero = r_dig == 16'h0000;
    // shift bit is a wildcard so every code bit is consumed
    w_clr  = w_exec && r_code ==? 9'b?_0010_0001;
    w_c0   = r_dig[3:0] == 4'd9;
    w_c1   = w_c0 && r_dig[7:4] == 4'd9;
    w_c2   = w_c1 && r_dig[11:8] == 4'd5;
    w_b0   = r_dig[3:0] == 4'd0;
    w_b1   = w_b0 && r_dig[7:4] == 4'd0;
    w_b2   = w_b1 && r_dig[11:8] == 4'd0;
    w_inc  = {w_c2 ? (r_dig[15:12] == 4'd9 ? 4'd0 : r_dig[15:12] + 4'd1) : r_dig[15:12],
              w_c1 ? (r_dig[11:8] == 4'd5 ? 4'd0 : r_dig[11:8] + 4'd1) : r_dig[11:8],
              w_c0 ? 4'd0 : r_dig[7:4] + 4'd1,
              w_c0 ? 4'd0 : r_dig[3:0] + 4'd1};
    w_inc[7:4] = w_c0 ? (r_dig[7:4] == 4'd9 ? 4'd0 : r_dig[7:4] + 4'd1) : r_dig[7:4];
    w_dec  = {w_b2 ? (r_dig[15:12] == 4'd0 ? 4'd9 : r_dig[15:12] - 4'd1) : r_dig[15:12],
              w_b1 ? (r_dig[11:8] == 4'd0 ? 4'd5 : r_dig[11:8] - 4'd1) : r_dig[11:8],
              w_b0 ? (r_dig[7:4] == 4'd0 ? 4'd9 : r_dig[7:4] - 4'd1) : r_dig[7:4],
              w_b0 ? 4'd9 : r_dig[3:0] - 4'd1};
  end
  // Later assignments override earlier ones: commands < tick < clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_code  <= '0;
      r_run   <= 1'b0;
      r_up    <= 1'b1;
      r_dig   <= '0;
      r_cnt   <= '0;
    end else begin
      r_rd    <= !w_exec && !kb.fifo_empty;
      r_state <= (!w_exec && !kb.fifo_empty) ? EXEC : IDLE;
      if (!w_exec && !kb.fifo_empty) r_code <= kb.rd_data;
      if (w_exec && r_code ==? 9'b?_0011_0100 && (r_up || !w_zero)) r_run <= 1'b1;
      if (w_exec && r_code ==? 9'b?_0100_1101) r_run <= 1'b0;
      if (w_exec && r_code ==? 9'b?_0011_1100) r_up <= 1'b1;
      if (w_exec && r_code ==? 9'b?_0010_0011) r_up <= 1'b0;
      if (r_run) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick && r_up) r_dig <= w_inc;
      // down-count stops at 0:00.0 and never wraps
      if (w_tick && !r_up && !w_zero) r_dig <= w_dec;
      if (w_tick && !r_up && (w_zero || w_dec == 16'h0000)) r_run <= 1'b0;
      if (w_clr) begin
        r_run <= 1'b0;
        r_dig <= '0;
        r_cnt <= '0;
      end
    end
  end
  assign kb.rd_fifo = r_rd;
  assign running    = r_run;
  assign up         = r_up;
  assign {m0, s1, s0, d0} = r_dig;
endmodule

// File: tb/tb_kb_stopwatch.sv
// tb_kb_stopwatch: scoreboard bench for kb_stopwatch with a queue-modelled keyboard FIFO.
module tb_kb_stopwatch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic running, up;
  logic [3:0] d0, s0, s1, m0;
  kb_stopwatch_if kb();
  kb_stopwatch #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .kb(kb),
    .running(running), .up(up), .d0(d0), .s0(s0), .s1(s1), .m0(m0)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int n_pop = 0;
  bit started = 1'b0;
  bit prev_rd = 1'b0;
  logic [8:0] fq[$];
  logic [17:0] exp_q[$];
  logic [17:0] prev_snap;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  function automatic logic [17:0] snap(input bit r, input bit u, input int t);
    int sec;
    sec = (t / 10) % 60;
    return {r, u, 4'(t / 600), 4'(sec / 10), 4'(sec % 10), 4'(t % 10)};
  endfunction
  task automatic refresh();
    kb.fifo_empty = fq.size() == 0;
    kb.rd_data = fq.size() != 0 ? fq[0] : 9'h000;
  endtask
  task automatic fpush(input logic [8:0] v);
    fq.push_back(v);
    refresh();
  endtask
  task automatic expect_snap(input bit r, input bit u, input int t);
    exp_q.push_back(snap(r, u, t));
  endtask
  task automatic wait_disp(input int t, input int budget);
    logic [17:0] e;
    int n;
    e = snap(1'b0, 1'b0, t);
    n = 0;
    while ({m0, s1, s0, d0} != e[15:0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_%0d", t), {m0, s1, s0, d0}, e[15:0]);
  endtask
  task automatic measure(output int n);
    int k;
    k = 0;
    while (!running && k < 20) begin
      @(negedge clk);
      k++;
    end
    n = 0;
    while (d0 == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  // FIFO model: pops on the edge where rd_fifo is 1, head updated just after the edge
  always @(posedge clk) begin
    if (kb.rd_fifo) begin
      chk("pop_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) void'(fq.pop_front());
    end
    #1 refresh();
  end
  // rd_fifo must be a single-cycle pulse
  always @(negedge clk) begin
    if (started && kb.rd_fifo) begin
      n_pop++;
      chk("rd_pulse", 32'(prev_rd), 32'd0);
    end
    prev_rd = kb.rd_fifo;
  end
  // scoreboard monitor: each change of the visible state pops one expectation
  always @(negedge clk) begin
    logic [17:0] cur;
    cur = {running, up, m0, s1, s0, d0};
    if (started && cur != prev_snap) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_change: got %0h expected %0h", cur, prev_snap);
      end else chk("display", cur, exp_q.pop_front());
      prev_snap = cur;
    end
  end
  initial begin
    int n, p0;
    refresh();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev_snap = snap(1'b0, 1'b1, 0);
    started = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_pops", n_pop, 0);
    chk("reset_state", {running, up, m0, s1, s0, d0}, snap(1'b0, 1'b1, 0));
    // start and count up through 0:01.0 to the 9:59.9 -> 0:00.0 wrap
    expect_snap(1'b1, 1'b1, 0);
    for (int t = 1; t < 6000; t++) expect_snap(1'b1, 1'b1, t);
    expect_snap(1'b1, 1'b1, 0);
    fpush(9'h034);
    wait_disp(10, 200);
    chk("g_pops", n_pop, 1);
    wait_disp(5998, 30000);
    wait_disp(5999, 20);
    wait_disp(0, 20);
    chk("wrap_running", running, 1'b1);
    // down count from 0:00.2 stops at zero
    expect_snap(1'b1, 1'b1, 1);
    expect_snap(1'b1, 1'b1, 2);
    wait_disp(2, 20);
    expect_snap(1'b1, 1'b0, 2);
    expect_snap(1'b1, 1'b0, 1);
    expect_snap(1'b0, 1'b0, 0);
    fpush(9'h023);
    fpush(9'h034);
    repeat (20) @(negedge clk);
    chk("down_stop", {running, m0, s1, s0, d0}, 17'h0);
    fpush(9'h034);
    repeat (10) @(negedge clk);
    chk("g_ignored", running, 1'b0);
    // pause at tick counter 2 keeps the phase; clear resets it
    expect_snap(1'b0, 1'b1, 0);
    expect_snap(1'b1, 1'b1, 0);
    expect_snap(1'b0, 1'b1, 0);
    fpush(9'h03C);
    fpush(9'h034);
    fpush(9'h04D);
    repeat (12) @(negedge clk);
    expect_snap(1'b1, 1'b1, 0);
    expect_snap(1'b1, 1'b1, 1);
    fpush(9'h034);
    measure(n);
    chk("resume_phase", n, 2);
    expect_snap(1'b0, 1'b1, 0);
    fpush(9'h021);
    repeat (6) @(negedge clk);
    chk("clear", {running, up, m0, s1, s0, d0}, snap(1'b0, 1'b1, 0));
    expect_snap(1'b1, 1'b1, 0);
    expect_snap(1'b1, 1'b1, 1);
    fpush(9'h034);
    measure(n);
    chk("clear_phase", n, 4);
    expect_snap(1'b0, 1'b1, 0);
    fpush(9'h021);
    repeat (6) @(negedge clk);
    // back-to-back entries, unknown code and shifted entry ignored
    expect_snap(1'b0, 1'b0, 0);
    fpush(9'h023);
    repeat (4) @(negedge clk);
    expect_snap(1'b0, 1'b1, 0);
    expect_snap(1'b1, 1'b1, 0);
    p0 = n_pop;
    fpush(9'h03C);
    fpush(9'h01C);
    fpush(9'h19C);
    fpush(9'h034);
    repeat (8) @(negedge clk);
    chk("burst_pops", n_pop - p0, 4);
    chk("burst_state", {running, up}, 2'b11);
    // asynchronous reset in the middle of a burst
    expect_snap(1'b0, 1'b1, 0);
    fpush(9'h03C);
    fpush(9'h01C);
    fpush(9'h19C);
    fpush(9'h034);
    repeat (3) @(negedge clk);
    chk("pre_reset_rd", kb.rd_fifo, 1'b1);
    #2 rst_n = 1'b0;
    fq.delete();
    refresh();
    #1;
    chk("async_rd", kb.rd_fifo, 1'b0);
    chk("async_state", {running, up, m0, s1, s0, d0}, snap(1'b0, 1'b1, 0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
